// File: rtl/fir_param_engine.sv
// AXI-lite configured, AXI-stream FIR: runtime tap count, signed wide accumulator, programmable output shift.
// Optional FIR_SAT_EN saturates the shifted output and adds a sticky sat flag in ctrl[6]; otherwise output wraps.
module fir_param_engine #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int MAX_TAPS    = 32,
  parameter int ACC_WIDTH   = 72
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast
);
  localparam int PTR_W  = $clog2(MAX_TAPS);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SH_MAX = ACC_WIDTH - pDATA_WIDTH;
  localparam logic [pADDR_WIDTH-1:0] A_CTRL  = pADDR_WIDTH'('h00);
  localparam logic [pADDR_WIDTH-1:0] A_LEN   = pADDR_WIDTH'('h10);
  localparam logic [pADDR_WIDTH-1:0] A_TAPN  = pADDR_WIDTH'('h14);
  localparam logic [pADDR_WIDTH-1:0] A_SHIFT = pADDR_WIDTH'('h18);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAIT_X, S_MAC, S_OUT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [pDATA_WIDTH-1:0] taps [MAX_TAPS];
  logic [pDATA_WIDTH-1:0] hist [MAX_TAPS];
  logic [CNT_W-1:0]       tap_num;
  logic [pDATA_WIDTH-1:0] data_length;
  logic [pDATA_WIDTH-1:0] smp_cnt;
  logic [5:0]             out_shift;
  logic                   ap_start, ap_done, tlast_err, sat_flag, ap_idle;
  logic [PTR_W-1:0]       wptr, hist_idx;
  logic [CNT_W-1:0]       mac_cnt;
  logic                   last_smp, mac_end;
  logic signed [ACC_WIDTH-1:0]     acc, prod_ext, acc_sh;
  logic signed [2*pDATA_WIDTH-1:0] prod;
  logic [5:0]             sh_eff;
  logic                   sat_ovf;
  logic [pDATA_WIDTH-1:0] out_val, rd_val, ctrl_val;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= pADDR_WIDTH'(64)) && (a < pADDR_WIDTH'(64 + 4*MAX_TAPS)) && (a[1:0] == 2'b00);
  endfunction

  // 0x40 is word 16, so the tap index is the word address minus 16, modulo the depth.
  function automatic logic [PTR_W-1:0] tap_idx(input logic [pADDR_WIDTH-1:0] a);
    return a[PTR_W+1:2] - PTR_W'(16);
  endfunction

  // AXI-lite write: address and data latched independently, committed once both are held.
  logic                   aw_hold, w_hold, wr_commit;
  logic [pADDR_WIDTH-1:0] wr_addr;
  logic [pDATA_WIDTH-1:0] wr_dat;
  assign wr_commit = aw_hold && w_hold;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      awready <= 1'b1;
      wready  <= 1'b1;
      aw_hold <= 1'b0;
      w_hold  <= 1'b0;
      wr_addr <= '0;
      wr_dat  <= '0;
    end else begin
      if (awvalid && awready) begin
        awready <= 1'b0;
        aw_hold <= 1'b1;
        wr_addr <= awaddr;
      end
      if (wvalid && wready) begin
        wready <= 1'b0;
        w_hold <= 1'b1;
        wr_dat <= wdata;
      end
      if (wr_commit) begin
        aw_hold <= 1'b0;
        w_hold  <= 1'b0;
        awready <= 1'b1;
        wready  <= 1'b1;
      end
    end
  end

  // AXI-lite read: value captured at the address handshake, held until accepted.
  logic rd_ctrl;
  assign rd_ctrl = arvalid && arready && (araddr == A_CTRL);

  always_comb begin
    ctrl_val    = '0;
    ctrl_val[0] = ap_start;
    ctrl_val[1] = ap_done;
    ctrl_val[2] = ap_idle;
    ctrl_val[3] = tlast_err;
    ctrl_val[4] = (state == S_WAIT_X);
    ctrl_val[5] = (state == S_OUT);
    ctrl_val[6] = sat_flag;
  end

  always_comb begin
    rd_val = '0;
    if (araddr == A_CTRL)       rd_val = ctrl_val;
    else if (araddr == A_LEN)   rd_val = data_length;
    else if (araddr == A_TAPN)  rd_val = pDATA_WIDTH'(tap_num);
    else if (araddr == A_SHIFT) rd_val = pDATA_WIDTH'(out_shift);
    else if (is_tap(araddr))    rd_val = ap_idle ? taps[tap_idx(araddr)] : '1;
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else if (arvalid && arready) begin
      arready <= 1'b0;
      rvalid  <= 1'b1;
      rdata   <= rd_val;
    end else if (rvalid && rready) begin
      rvalid  <= 1'b0;
      arready <= 1'b1;
      rdata   <= '0;
    end
  end

  // Configuration is only writable while idle; sticky bits let a set beat a same-cycle clear.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < MAX_TAPS; i++) taps[i] <= '0;
      tap_num     <= CNT_W'(1);
      data_length <= '0;
      out_shift   <= '0;
      ap_start    <= 1'b0;
      ap_done     <= 1'b0;
      tlast_err   <= 1'b0;
    end else begin
      ap_start <= 1'b0;
      if (wr_commit && ap_idle) begin
        if (wr_addr == A_CTRL) begin
          if (wr_dat[0] && (data_length != '0)) ap_start <= 1'b1;
        end else if (wr_addr == A_LEN) begin
          data_length <= wr_dat;
        end else if (wr_addr == A_TAPN) begin
          if (wr_dat == '0)                             tap_num <= CNT_W'(1);
          else if (wr_dat > pDATA_WIDTH'(MAX_TAPS))     tap_num <= CNT_W'(MAX_TAPS);
          else                                          tap_num <= wr_dat[CNT_W-1:0];
        end else if (wr_addr == A_SHIFT) begin
          out_shift <= wr_dat[5:0];
        end else if (is_tap(wr_addr)) begin
          taps[tap_idx(wr_addr)] <= wr_dat;
        end
      end
      if (rd_ctrl) begin
        ap_done   <= 1'b0;
        tlast_err <= 1'b0;
      end
      if (state == S_OUT && state_nxt == S_DONE) ap_done <= 1'b1;
      if (state == S_WAIT_X && ss_tvalid && ss_tlast && (smp_cnt != data_length - pDATA_WIDTH'(1)))
        tlast_err <= 1'b1;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) state <= S_IDLE;
    else             state <= state_nxt;
  end

  assign mac_end = (mac_cnt == tap_num - CNT_W'(1));

  always_comb begin
    state_nxt = state;
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    sm_tdata  = '0;
    sm_tlast  = 1'b0;
    ap_idle   = 1'b0;
    case (state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) state_nxt = S_CLEAR;
      end
      S_CLEAR: state_nxt = S_WAIT_X;
      S_WAIT_X: begin
        ss_tready = 1'b1;
        if (ss_tvalid) state_nxt = S_MAC;
      end
      S_MAC: if (mac_end) state_nxt = S_OUT;
      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tdata  = out_val;
        sm_tlast  = last_smp;
        if (sm_tready) state_nxt = last_smp ? S_DONE : S_WAIT_X;
      end
      S_DONE: begin
        ap_idle   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // wptr stays on the newest sample for the whole MAC so tap k meets sample n-k.
  assign hist_idx = wptr - mac_cnt[PTR_W-1:0];
  assign prod     = $signed(taps[mac_cnt[PTR_W-1:0]]) * $signed(hist[hist_idx]);
  assign prod_ext = {{(ACC_WIDTH-2*pDATA_WIDTH){prod[2*pDATA_WIDTH-1]}}, prod};

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < MAX_TAPS; i++) hist[i] <= '0;
      wptr     <= '0;
      mac_cnt  <= '0;
      acc      <= '0;
      smp_cnt  <= '0;
      last_smp <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          for (int i = 0; i < MAX_TAPS; i++) hist[i] <= '0;
          wptr     <= '0;
          smp_cnt  <= '0;
          last_smp <= 1'b0;
        end
        S_WAIT_X: if (ss_tvalid) begin
          hist[wptr] <= ss_tdata;
          acc        <= '0;
          mac_cnt    <= '0;
          last_smp   <= ss_tlast || (smp_cnt == data_length - pDATA_WIDTH'(1));
        end
        S_MAC: begin
          acc     <= acc + prod_ext;
          mac_cnt <= mac_cnt + CNT_W'(1);
          if (mac_end) wptr <= wptr + PTR_W'(1);
        end
        S_OUT: if (sm_tready) smp_cnt <= smp_cnt + pDATA_WIDTH'(1);
        default: ;
      endcase
    end
  end

  assign sh_eff = (out_shift > 6'(SH_MAX)) ? 6'(SH_MAX) : out_shift;
  assign acc_sh = acc >>> sh_eff;
  // Overflow when the bits above the output MSB are not a pure sign extension.
  assign sat_ovf = !((&acc_sh[ACC_WIDTH-1:pDATA_WIDTH-1]) || !(|acc_sh[ACC_WIDTH-1:pDATA_WIDTH-1]));

`ifdef FIR_SAT_EN
  assign out_val = !sat_ovf ? acc_sh[pDATA_WIDTH-1:0] :
                   acc_sh[ACC_WIDTH-1] ? {1'b1, {(pDATA_WIDTH-1){1'b0}}} : {1'b0, {(pDATA_WIDTH-1){1'b1}}};

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      sat_flag <= 1'b0;
    end else begin
      if (rd_ctrl) sat_flag <= 1'b0;
      if (state == S_OUT && sm_tready && sat_ovf) sat_flag <= 1'b1;
    end
  end
`else
  logic unused_sat;
  assign out_val    = acc_sh[pDATA_WIDTH-1:0];
  assign sat_flag   = 1'b0;
  assign unused_sat = sat_ovf;
`endif

endmodule

// File: tb/tb_fir_param_engine.sv
// Table-driven, scoreboarded bench for fir_param_engine (honours FIR_SAT_EN when defined).
module tb_fir_param_engine;
  logic        axis_clk, axis_rst_n;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic        ss_tvalid, ss_tready, ss_tlast, sm_tvalid, sm_tready, sm_tlast;
  logic [31:0] ss_tdata, sm_tdata;

  fir_param_engine dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  typedef struct {
    int          grp;
    logic [31:0] din;
    logic        din_last;
    logic [31:0] dout;
    logic        dout_last;
  } vec_t;

  vec_t        vecs[$];
  logic [32:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          out_cnt  = 0;

  task automatic add_vec(input int g, input int di, input bit dl, input int dq, input bit ql);
    vec_t v;
    v.grp = g; v.din = di; v.din_last = dl; v.dout = dq; v.dout_last = ql;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout, required handshake", name);
  endtask

  always @(negedge axis_clk) begin : monitor
    logic [32:0] e;
    if (sm_tvalid && sm_tready) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_unexpected: got data=%h last=%b, required no output", sm_tdata, sm_tlast);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("out_data[%0d]", out_cnt), sm_tdata, e[31:0]);
        chk($sformatf("out_last[%0d]", out_cnt), {31'd0, sm_tlast}, {31'd0, e[32]});
      end
    end
  end

  task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
    bit aw_ok, w_ok, aw_hs, w_hs;
    int cnt;
    @(posedge axis_clk); #1;
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d;
    aw_ok = 0; w_ok = 0; cnt = 0;
    while (!(aw_ok && w_ok) && cnt < 50) begin
      @(negedge axis_clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge axis_clk); #1;
      if (aw_hs) begin aw_ok = 1; awvalid = 1'b0; end
      if (w_hs)  begin w_ok  = 1; wvalid  = 1'b0; end
      cnt++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_ok && w_ok)) timeout_fail("axil_write");
  endtask

  task automatic axil_read(input logic [11:0] a, output logic [31:0] d);
    int cnt;
    bit ok;
    d = '0;
    @(posedge axis_clk); #1;
    arvalid = 1'b1; araddr = a;
    ok = 0; cnt = 0;
    while (!ok && cnt < 50) begin
      @(negedge axis_clk);
      if (arready) ok = 1; else cnt++;
    end
    @(posedge axis_clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    if (!ok) timeout_fail("axil_ar");
    ok = 0; cnt = 0;
    while (!ok && cnt < 50) begin
      @(negedge axis_clk);
      if (rvalid) begin ok = 1; d = rdata; end else cnt++;
    end
    @(posedge axis_clk); #1;
    rready = 1'b0;
    if (!ok) timeout_fail("axil_r");
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] v;
    axil_read(a, v);
    chk(name, v, exp);
  endtask

  task automatic send(input logic [31:0] d, input logic l, input bit push, input logic [32:0] e);
    int cnt;
    bit hs;
    @(posedge axis_clk); #1;
    ss_tvalid = 1'b1; ss_tdata = d; ss_tlast = l;
    hs = 0; cnt = 0;
    while (!hs && cnt < 300) begin
      @(negedge axis_clk);
      if (ss_tready) begin
        hs = 1;
        if (push) exp_q.push_back(e);
      end else cnt++;
    end
    @(posedge axis_clk); #1;
    ss_tvalid = 1'b0; ss_tlast = 1'b0; ss_tdata = '0;
    if (!hs) timeout_fail("ss_handshake");
  endtask

  task automatic run_group(input int g, input int gap);
    foreach (vecs[i]) begin
      if (vecs[i].grp == g) begin
        repeat (gap) @(posedge axis_clk);
        send(vecs[i].din, vecs[i].din_last, 1'b1, {vecs[i].dout_last, vecs[i].dout});
      end
    end
  endtask

  task automatic drain();
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 500) begin
      @(negedge axis_clk);
      cnt++;
    end
    if (exp_q.size() != 0) timeout_fail("drain");
    repeat (3) @(posedge axis_clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] rv;
    int          base;
    int          tap1[11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    int          exp1[8]  = '{0, 0, -10, -29, -25, 35, 158, 337};

    for (int i = 0; i < 8; i++) add_vec(1, i, i == 7, exp1[i], i == 7);
    add_vec(2, 1, 0, 1, 0);  add_vec(2, 2, 0, 3, 0);  add_vec(2, 3, 0, 6, 0);
    add_vec(2, 4, 0, 10, 0); add_vec(2, 5, 0, 14, 0); add_vec(2, 6, 0, 18, 1);
    add_vec(3, 5, 0, 5, 0);  add_vec(3, -3, 0, -3, 0); add_vec(3, 7, 0, 7, 0); add_vec(3, 9, 1, 9, 1);
`ifdef FIR_SAT_EN
    add_vec(4, 32'h7FFFFFFF, 1, 32'h7FFFFFFF, 1);
`else
    add_vec(4, 32'h7FFFFFFF, 1, 32'hF0000000, 1);
`endif

    awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0;
    ss_tvalid = 0; ss_tdata = '0; ss_tlast = 0; sm_tready = 1;
    axis_rst_n = 0;
    repeat (3) @(posedge axis_clk);
    #1 axis_rst_n = 1;

    @(negedge axis_clk);
    chk("rst_awready", {31'd0, awready}, 32'd1);
    chk("rst_wready", {31'd0, wready}, 32'd1);
    chk("rst_arready", {31'd0, arready}, 32'd1);
    chk("rst_outs", {28'd0, rvalid, sm_tvalid, ss_tready, sm_tlast}, 32'd0);
    rd_chk("rst_ctrl", 12'h000, 32'h4);
    rd_chk("rst_tap_num", 12'h014, 32'd1);
    rd_chk("unmapped", 12'h020, 32'd0);
    axil_write(12'h014, 32'd0);
    rd_chk("tap_num_clamp_lo", 12'h014, 32'd1);
    axil_write(12'h014, 32'd100);
    rd_chk("tap_num_clamp_hi", 12'h014, 32'd32);

    // Symmetric 11-tap filter over a ramp.
    axil_write(12'h014, 32'd11);
    for (int i = 0; i < 11; i++) axil_write(12'(64 + 4*i), tap1[i]);
    rd_chk("tap3_idle", 12'h04C, 32'd23);
    axil_write(12'h010, 32'd8);
    axil_write(12'h018, 32'd0);
    axil_write(12'h000, 32'd1);
    run_group(1, 0);
    drain();
    rd_chk("ctrl_done", 12'h000, 32'h6);
    rd_chk("ctrl_done_cleared", 12'h000, 32'h4);

    // Output backpressure on the second result.
    axil_write(12'h014, 32'd4);
    for (int i = 0; i < 4; i++) axil_write(12'(64 + 4*i), 32'd1);
    axil_write(12'h010, 32'd6);
    axil_write(12'h000, 32'd1);
    base = out_cnt;
    fork
      run_group(2, 0);
      begin : stall
        int          cnt;
        logic [31:0] held;
        cnt = 0;
        while (out_cnt < base + 1 && cnt < 300) begin @(negedge axis_clk); cnt++; end
        @(posedge axis_clk); #1;
        sm_tready = 1'b0;
        cnt = 0;
        while (!sm_tvalid && cnt < 300) begin @(negedge axis_clk); cnt++; end
        chk("stall_valid", {31'd0, sm_tvalid}, 32'd1);
        held = sm_tdata;
        for (int i = 0; i < 5; i++) begin
          @(negedge axis_clk);
          chk("stall_hold_data", sm_tdata, held);
          chk("stall_ss_tready", {31'd0, ss_tready}, 32'd0);
        end
        @(posedge axis_clk); #1;
        sm_tready = 1'b1;
      end
    join
    drain();

    // Early tlast plus writes attempted while busy.
    axil_write(12'h014, 32'd1);
    axil_write(12'h010, 32'd10);
    axil_write(12'h000, 32'd1);
    fork
      run_group(3, 4);
      begin : busy_axi
        logic [31:0] bv;
        repeat (3) @(posedge axis_clk);
        axil_write(12'h040, 32'h55);
        axil_write(12'h000, 32'h1);
        axil_read(12'h040, bv);
        chk("busy_tap_read", bv, 32'hFFFFFFFF);
      end
    join
    drain();
    rd_chk("ctrl_tlast_err", 12'h000, 32'hE);
    rd_chk("ctrl_tlast_cleared", 12'h000, 32'h4);
    rd_chk("tap0_unchanged", 12'h040, 32'd1);

    // Shifted full-scale product.
    axil_write(12'h040, 32'h7FFFFFFF);
    axil_write(12'h010, 32'd1);
    axil_write(12'h018, 32'd4);
    axil_write(12'h000, 32'd1);
    run_group(4, 0);
    drain();
`ifdef FIR_SAT_EN
    rd_chk("ctrl_sat", 12'h000, 32'h46);
`else
    rd_chk("ctrl_wrap", 12'h000, 32'h6);
`endif
    rd_chk("ctrl_sat_cleared", 12'h000, 32'h4);

    // Reset in the middle of a long MAC.
    axil_write(12'h014, 32'd32);
    axil_write(12'h010, 32'd4);
    axil_write(12'h000, 32'd1);
    send(32'd5, 1'b0, 1'b0, 33'd0);
    repeat (5) @(posedge axis_clk);
    #1 axis_rst_n = 1'b0;
    #1;
    chk("midrst_sm_tvalid", {31'd0, sm_tvalid}, 32'd0);
    chk("midrst_ss_tready", {31'd0, ss_tready}, 32'd0);
    chk("midrst_awready", {31'd0, awready}, 32'd1);
    repeat (2) @(posedge axis_clk);
    #1 axis_rst_n = 1'b1;
    repeat (60) @(posedge axis_clk);
    rd_chk("midrst_ctrl", 12'h000, 32'h4);
    rd_chk("midrst_tap_num", 12'h014, 32'd1);
    rd_chk("midrst_len", 12'h010, 32'd0);
    rd_chk("midrst_tap0", 12'h040, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
